// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic-array operand feeder.
// Holds the default element width, the feeder FSM state type and a lane-slice helper.
// No ports; imported by systolic_skew_feeder.
package systolic_pkg;

  localparam int DEF_DATA_WIDTH = 8;

  // Upper bounds for the lane-slice helper; any packed bus up to this size works.
  localparam int LANE_BUS_MAX = 1024;
  localparam int LANE_MAX     = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } feeder_state_t;

  // Returns lane idx (width bits wide) of a packed bus, right-aligned.
  // Callers zero-extend the bus on the way in and truncate the result on the way out.
  function automatic logic [LANE_MAX-1:0] lane_of(input logic [LANE_BUS_MAX-1:0] bus,
                                                  input int unsigned idx,
                                                  input int unsigned width);
    logic [LANE_BUS_MAX-1:0] shifted;
    shifted = bus >> (idx * width);
    return LANE_MAX'(shifted);
  endfunction

endpackage

// File: rtl/systolic_skew_feeder.sv
// Drains ARRAY_SIZE row FIFOs into the west edge of a systolic array with a diagonal skew (row i lags row 0 by i cycles).
// Latency: len+ARRAY_SIZE-1 RUN cycles, one DRAIN cycle, then a one-cycle done pulse; a_out trails fifo_read by one cycle.
// Backpressure: any due-but-empty FIFO stalls every lane for that cycle, inserting an all-zero bubble and preserving the skew.
// Ports: clk/reset (sync, active-high); start/len request a run; fifo_empty/fifo_data/fifo_read talk to the row FIFOs;
//        a_out/a_valid feed the array (zero-padded outside each row's window); busy covers RUN and DRAIN; done pulses at the end.
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ARRAY_SIZE = 4,
  parameter int MAX_LEN    = 16,
  parameter int LEN_WIDTH  = 5
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [LEN_WIDTH-1:0]             len,
  input  logic [ARRAY_SIZE-1:0]            fifo_empty,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] fifo_data,
  output logic [ARRAY_SIZE-1:0]            fifo_read,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0] a_out,
  output logic [ARRAY_SIZE-1:0]            a_valid,
  output logic                             busy,
  output logic                             done
);

  // Wide enough for len + ARRAY_SIZE without wrapping.
  localparam int TW = LEN_WIDTH + $clog2(ARRAY_SIZE);

  feeder_state_t         state;
  logic [TW-1:0]         t;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [ARRAY_SIZE-1:0] need;
  logic [ARRAY_SIZE-1:0] a_valid_q;
  logic                  stall;
  logic                  busy_q;
  logic                  done_q;
  logic [TW-1:0]         len_ext;
  logic [TW-1:0]         last_t;

  assign len_ext = TW'(len_q);
  // Final RUN step: the last row's last element is read when t reaches len_q+ARRAY_SIZE-2.
  assign last_t  = len_ext + TW'(ARRAY_SIZE - 2);

  // Per-row read window: row i is due while i <= t < i+len_q.
  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_row
    assign need[i] = (state == RUN) && (t >= TW'(i)) && (t < TW'(i) + len_ext);

    // Lanes outside the valid window are forced to zero so the array sees padding.
    assign a_out[i*DATA_WIDTH +: DATA_WIDTH] =
      a_valid_q[i] ? DATA_WIDTH'(lane_of(LANE_BUS_MAX'(fifo_data), i, DATA_WIDTH))
                   : '0;
  end

  // One empty-but-due FIFO freezes all rows; reading the others would skew the wavefront.
  assign stall     = |(need & fifo_empty);
  assign fifo_read = stall ? '0 : need;

  assign a_valid = a_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      t         <= '0;
      len_q     <= '0;
      a_valid_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // Matches the FIFO's one-cycle read latency.
      a_valid_q <= fifo_read;
      done_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              // Out-of-range lengths are clamped to the FIFO depth.
              len_q  <= (len > LEN_WIDTH'(MAX_LEN)) ? LEN_WIDTH'(MAX_LEN) : len;
              t      <= '0;
              state  <= RUN;
              busy_q <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!stall) begin
            t <= t + 1'b1;
            if (t == last_t) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder with a behavioural FIFO per row and a per-lane data scoreboard.
module tb_systolic_skew_feeder;

  localparam int DW   = 8;
  localparam int AS   = 4;
  localparam int ML   = 16;
  localparam int LW   = 5;
  localparam int MEMD = 128;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [LW-1:0]     len;
  logic [AS-1:0]     fifo_empty;
  logic [AS*DW-1:0]  fifo_data;
  logic [AS-1:0]     fifo_read;
  logic [AS*DW-1:0]  a_out;
  logic [AS-1:0]     a_valid;
  logic              busy;
  logic              done;

  int checks   = 0;
  int failures = 0;

  // Behavioural FIFOs: written only by the stimulus, read pointer advanced only by the model.
  logic [DW-1:0] mem [AS][MEMD];
  int            wr_ptr [AS];
  int            rd_ptr [AS];
  logic [DW-1:0] fifo_dout [AS];
  logic [AS-1:0] hide;
  logic          mon_en = 1'b0;

  // Expected element stream per lane.
  logic [DW-1:0] exp_q [AS][$];

  always #5 clk = ~clk;

  systolic_skew_feeder #(
    .DATA_WIDTH(DW), .ARRAY_SIZE(AS), .MAX_LEN(ML), .LEN_WIDTH(LW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read(fifo_read),
    .a_out(a_out), .a_valid(a_valid), .busy(busy), .done(done)
  );

  for (genvar i = 0; i < AS; i++) begin : g_fifo
    assign fifo_empty[i]          = (wr_ptr[i] == rd_ptr[i]) || hide[i];
    assign fifo_data[i*DW +: DW]  = fifo_dout[i];

    always @(posedge clk) begin
      if (fifo_read[i] && (wr_ptr[i] != rd_ptr[i])) begin
        fifo_dout[i] <= mem[i][rd_ptr[i]];
        rd_ptr[i]    <= rd_ptr[i] + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] lane(input logic [AS*DW-1:0] bus, input int i);
    return bus[i*DW +: DW];
  endfunction

  task automatic push(input int row, input logic [DW-1:0] v);
    mem[row][wr_ptr[row]] = v;
    wr_ptr[row] = wr_ptr[row] + 1;
    exp_q[row].push_back(v);
  endtask

  task automatic load_rows(input int n, input int base);
    for (int r = 0; r < AS; r++)
      for (int k = 0; k < n; k++)
        push(r, DW'(base + 10*r + k));
  endtask

  task automatic flush_all();
    for (int r = 0; r < AS; r++) begin
      wr_ptr[r] = rd_ptr[r];
      exp_q[r].delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one cycle; returns at the start of C0.
  task automatic kick(input int l);
    start = 1'b1;
    len   = LW'(l);
    tick();
    start = 1'b0;
  endtask

  // Scoreboard: every valid lane must deliver the next queued element; idle lanes must be zero.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < AS; i++) begin
        if (fifo_read[i] && (wr_ptr[i] == rd_ptr[i]))
          chk($sformatf("underflow_lane%0d", i), 64'(fifo_read[i]), 64'd0);
        if (a_valid[i] === 1'b1) begin
          if (exp_q[i].size() == 0)
            chk($sformatf("sb_unexpected_lane%0d", i), 64'(a_valid[i]), 64'd0);
          else
            chk($sformatf("sb_data_lane%0d", i), 64'(lane(a_out, i)), 64'(exp_q[i].pop_front()));
        end else begin
          chk($sformatf("pad_lane%0d", i), 64'(lane(a_out, i)), 64'd0);
        end
      end
    end
  end

  // Checks a stall-free run of length l from C0 through the cycle after done.
  task automatic run_nominal(input int l, input int lane2_base);
    logic [AS-1:0] erd, ev;
    for (int c = 0; c < l + 6; c++) begin
      @(negedge clk);
      for (int i = 0; i < AS; i++) begin
        erd[i] = (c >= i) && (c < i + l);
        ev[i]  = (c >= i + 1) && (c <= i + l);
      end
      chk($sformatf("len%0d_rd_c%0d", l, c),    64'(fifo_read), 64'(erd));
      chk($sformatf("len%0d_vld_c%0d", l, c),   64'(a_valid),   64'(ev));
      chk($sformatf("len%0d_busy_c%0d", l, c),  64'(busy),      64'(c <= l + 3));
      chk($sformatf("len%0d_done_c%0d", l, c),  64'(done),      64'(c == l + 4));
      if (lane2_base >= 0 && c >= 3 && c <= l + 2)
        chk($sformatf("len%0d_lane2_c%0d", l, c), 64'(lane(a_out, 2)), 64'(lane2_base + c - 3));
      tick();
    end
  endtask

  initial begin
    for (int r = 0; r < AS; r++) begin
      wr_ptr[r]    = 0;
      rd_ptr[r]    = 0;
      fifo_dout[r] = '0;
    end
    hide  = '0;
    reset = 1'b1;
    start = 1'b1;
    len   = LW'(3);

    // 1. Reset dominates a held start.
    tick();
    mon_en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("rst_rd_%0d", c),   64'(fifo_read), 64'd0);
      chk($sformatf("rst_vld_%0d", c),  64'(a_valid),   64'd0);
      chk($sformatf("rst_aout_%0d", c), 64'(a_out),     64'd0);
      chk($sformatf("rst_busy_%0d", c), 64'(busy),      64'd0);
      chk($sformatf("rst_done_%0d", c), 64'(done),      64'd0);
      tick();
    end
    reset = 1'b0;
    start = 1'b0;
    tick();

    // 2. Basic run, len=3.
    load_rows(3, 0);
    kick(3);
    run_nominal(3, 20);
    for (int r = 0; r < AS; r++)
      chk($sformatf("basic_drained_%0d", r), 64'(exp_q[r].size()), 64'd0);

    // 3. Row 2 empty for one cycle at C2.
    load_rows(3, 0);
    kick(3);
    for (int c = 0; c < 10; c++) begin
      hide[2] = (c == 2);
      @(negedge clk);
      if (c == 2) chk("stall_rd_c2", 64'(fifo_read), 64'd0);
      if (c == 3) begin
        chk("stall_vld_c3", 64'(a_valid), 64'd0);
        chk("stall_rd_c3", 64'(fifo_read), 64'b0111);
      end
      chk($sformatf("stall_busy_c%0d", c), 64'(busy), 64'(c <= 7));
      chk($sformatf("stall_done_c%0d", c), 64'(done), 64'(c == 8));
      tick();
    end
    hide = '0;
    for (int r = 0; r < AS; r++)
      chk($sformatf("stall_drained_%0d", r), 64'(exp_q[r].size()), 64'd0);

    // 4. len=0 completes immediately with no reads.
    start = 1'b1;
    len   = '0;
    @(negedge clk);
    chk("len0_rd_start", 64'(fifo_read), 64'd0);
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("len0_done", 64'(done), 64'd1);
    chk("len0_busy", 64'(busy), 64'd0);
    chk("len0_rd",   64'(fifo_read), 64'd0);
    tick();
    @(negedge clk);
    chk("len0_done_once", 64'(done), 64'd0);
    tick();

    // 5. Ignored restart at C2, reset at C3, then a clean len=2 run.
    load_rows(3, 100);
    kick(3);
    for (int c = 0; c < 8; c++) begin
      start = (c == 2);
      len   = (c == 2) ? LW'(7) : LW'(3);
      reset = (c == 3);
      @(negedge clk);
      if (c == 3) chk("abort_rd_c3_ignored_start", 64'(fifo_read), 64'b1110);
      if (c >= 4) begin
        chk($sformatf("abort_rd_c%0d", c),   64'(fifo_read), 64'd0);
        chk($sformatf("abort_vld_c%0d", c),  64'(a_valid),   64'd0);
        chk($sformatf("abort_busy_c%0d", c), 64'(busy),      64'd0);
      end
      chk($sformatf("abort_done_c%0d", c), 64'(done), 64'd0);
      tick();
    end
    start = 1'b0;
    reset = 1'b0;
    flush_all();
    load_rows(2, 50);
    kick(2);
    run_nominal(2, -1);

    // 6. Maximum length.
    load_rows(16, 0);
    kick(16);
    run_nominal(16, -1);
    for (int r = 0; r < AS; r++)
      chk($sformatf("max_drained_%0d", r), 64'(exp_q[r].size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
